adjacent_diff_1x8x32bit: RTL and testbench
==========================================

ADJACENT_DIFF_1X8X32BIT -- requirements
Module: adjacent_diff_1x8x32bit

Interface
- REQ-001: Parameter LAT, default 4, SHALL set the pipeline latency in cycles from in_v to out_v; the only legal value is 4.
- REQ-002: Port clk, input, 1 bit: single clock; all state SHALL update on its rising edge.
- REQ-003: Port reset, input, 1 bit: asynchronous, active-low reset.
- REQ-004: Port vrd, input, 3 bits: destination vector register name; value 0 also marks a stream restart.
- REQ-005: Port in_v, input, 1 bit: in8 and vrd are valid this cycle.
- REQ-006: Port in8, input, 256 bits: eight 32-bit unsigned lanes; lane k occupies bits [32k+31:32k].
- REQ-007: Port out_v, output, 1 bit: out8 and out_vrd are valid this cycle.
- REQ-008: Port out8, output, 256 bits: eight 32-bit difference lanes, same lane packing as in8.
- REQ-009: Port out_vrd, output, 3 bits: the vrd that accompanied the corresponding input vector.

Function
- REQ-010: The block SHALL accept one vector on every cycle that in_v=1, with no backpressure and no input-side stall.
- REQ-011: For an accepted vector, the block SHALL compute out lane 0 = in lane 0 - C and, for k=1..7, out lane k = in lane k - in lane k-1.
- REQ-012: Every subtraction SHALL wrap modulo 2^32 with no saturation and no flags.
- REQ-013: C SHALL be in lane 7 of the most recently accepted vector.
- REQ-014: C SHALL be 0 when the current vector has vrd=0, or when no vector has been accepted since reset.
- REQ-015: The carry register SHALL load in lane 7 on every accepted vector, including vectors with vrd=0.
- REQ-016: The carry register SHALL hold its value on cycles with in_v=0, so bubbles of any length between vectors SHALL NOT affect C.
- REQ-017: Back-to-back vectors on consecutive cycles SHALL use the immediately preceding vector's lane 7 as C, with no bubble inserted; carry forwarding is mandatory.
- REQ-018: Each result SHALL appear with out_v=1 exactly 4 cycles after its in_v=1 cycle.
- REQ-019: Results SHALL leave in acceptance order, one per cycle.
- REQ-020: out_vrd SHALL equal the vrd accepted with the same vector.
- REQ-021: Pipeline stages: S1 registers the input and C; S2 computes the eight lane subtractions; S3 is a pass register; S4 is the output register.
- REQ-022: Validity SHALL be carried in a 4-bit valid shift register, and vrd in a 12-bit shift register alongside it.
- REQ-023: out8 and out_vrd SHALL be ignored by consumers when out_v=0.
- REQ-024: Data registers MAY update on invalid cycles; the valid and carry registers SHALL NOT.
- REQ-025: The block SHALL be the exact inverse of the team's 8-lane prefix-sum instruction: prefix-summing the output stream, with restart on the same vrd=0 vectors, SHALL reproduce the input stream bit-exactly.

Reset
- REQ-026: While reset=0, all valid bits, vrd shift registers, the carry register and all data pipeline registers SHALL be 0, asynchronously, without waiting for a clk edge.
- REQ-027: While reset=0, outputs SHALL be out_v=0, out8=0 and out_vrd=0.
- REQ-028: Deassertion of reset SHALL be taken synchronously to clk.
- REQ-029: The first vector after deassertion SHALL use C=0.
- REQ-030: If reset asserts while vectors are in flight, those vectors SHALL be discarded and never produce out_v.
- REQ-031: After a mid-stream reset, the next accepted vector SHALL use C=0 regardless of its vrd.

Verification
- REQ-032: Single vector after reset: in8 lanes 0..7 = 5,7,7,10,0,1,1,100, vrd=3 -> exactly 4 cycles later out_v=1, out_vrd=3, out8 = 5,2,0,3,0xFFFFFFF6,1,0,99.
- REQ-033: Back-to-back carry: vector A = all lanes 10, then next cycle vector B = lanes 12..19 (both vrd=1) -> out lanes for B = 2,1,1,1,1,1,1,1; out lanes for A = 10,0,0,0,0,0,0,0.
- REQ-034: Bubble hold and restart: send A (lane 7 = 50), 6 idle cycles, then B with lane 0 = 60 and vrd=2 -> B lane 0 = 10; then C with lane 0 = 60 and vrd=0 -> C lane 0 = 60.
- REQ-035: Wrap: previous lane 7 = 0xFFFFFFFF, new lane 0 = 0 -> out lane 0 = 1; lanes 0,0xFFFFFFFF -> out lane 1 = 0xFFFFFFFF.
- REQ-036: Mid-operation reset: 3 vectors issued on consecutive cycles, reset pulled low 2 cycles after the first -> out_v=0 immediately and no results emitted; the first post-reset vector with lane 0 = 9 -> out lane 0 = 9.
- REQ-037: Random round-trip: 10,000 random vectors with random bubbles and random vrd (about 10% vrd=0) -> the prefix-sum reference model applied to the outputs reproduces the inputs, and each result's latency is exactly 4 cycles.

Source files
------------

// File: rtl/adjacent_diff_1x8x32bit.sv
// ---------------------------------------------------------------------------
// adjacent_diff_1x8x32bit
//
// Eight-lane adjacent-difference instruction. It is the exact inverse of the
// 8-lane prefix-sum: each output lane is the input lane minus its left
// neighbour. Lane 0 subtracts the carry C, which is lane 7 of the previous
// accepted vector. A vector whose vrd is 0 restarts the stream, so it uses
// C = 0.
//
// Pipeline, fixed latency LAT = 4:
//   S1  register the input vector, vrd and the selected carry
//   S2  eight 32-bit wrapping subtractions
//   S3  pass register
//   S4  output register
//
// Ports
//   clk      in   1    rising-edge clock
//   reset    in   1    asynchronous active-low reset
//   vrd      in   3    destination register; 0 marks a stream restart
//   in_v     in   1    in8/vrd valid (no backpressure)
//   in8      in   256  eight 32-bit lanes, lane k at [32k+31:32k]
//   out_v    out  1    out8/out_vrd valid
//   out8     out  256  eight 32-bit difference lanes
//   out_vrd  out  3    vrd that came in with this result
// ---------------------------------------------------------------------------
module adjacent_diff_1x8x32bit #(
  parameter int LAT = 4  // only 4 is supported
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [2:0]   vrd,
  input  logic         in_v,
  input  logic [255:0] in8,
  output logic         out_v,
  output logic [255:0] out8,
  output logic [2:0]   out_vrd
);

  // Control shift registers run alongside the data pipeline
  logic [LAT-1:0]   vld_q,   vld_d;
  logic [3*LAT-1:0] vrdSr_q, vrdSr_d;

  // Carry: lane 7 of the most recent accepted vector
  logic [31:0]      carry_q, carry_d;

  // Data pipeline registers
  logic [255:0]     s1Data_q;
  logic [31:0]      s1C_q,   s1C_d;
  logic [255:0]     s2Diff_q, s2Diff_d;
  logic [255:0]     s3Diff_q;
  logic [255:0]     s4Diff_q;

  // The carry register already holds the previous vector's lane 7 when the
  // next vector arrives. Back-to-back vectors are therefore forwarded
  // naturally, with no bubble. A restart vector forces C to 0, but the
  // carry register still loads its lane 7.
  always_comb begin
    carry_d = carry_q;
    s1C_d   = (vrd == 3'd0) ? 32'd0 : carry_q;
    vld_d   = {vld_q[LAT-2:0], in_v};
    vrdSr_d = {vrdSr_q[3*LAT-4:0], vrd};
    if (in_v) begin
      carry_d = in8[255:224];
    end
  end

  // Lane subtractions, all wrapping modulo 2^32
  always_comb begin
    s2Diff_d         = '0;
    s2Diff_d[31:0]   = s1Data_q[31:0] - s1C_q;
    for (int k = 1; k < 8; k++) begin
      s2Diff_d[32*k +: 32] = s1Data_q[32*k +: 32] - s1Data_q[32*(k-1) +: 32];
    end
  end

  // Control and carry state
  // Carry holds across bubbles. The valid bits shift every cycle, so
  // bubbles stay bubbles.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_q   <= '0;
      vrdSr_q <= '0;
      carry_q <= '0;
    end else begin
      vld_q   <= vld_d;
      vrdSr_q <= vrdSr_d;
      carry_q <= carry_d;
    end
  end

  // Data pipeline
  // These registers advance every cycle. Contents on invalid cycles are
  // meaningless and are masked by the valid bits.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1Data_q <= '0;
      s1C_q    <= '0;
      s2Diff_q <= '0;
      s3Diff_q <= '0;
      s4Diff_q <= '0;
    end else begin
      s1Data_q <= in8;
      s1C_q    <= s1C_d;
      s2Diff_q <= s2Diff_d;
      s3Diff_q <= s2Diff_q;
      s4Diff_q <= s3Diff_q;
    end
  end

  assign out_v   = vld_q[LAT-1];
  assign out8    = s4Diff_q;
  assign out_vrd = vrdSr_q[3*LAT-1 -: 3];

endmodule

// File: tb/tb_adjacent_diff_1x8x32bit.sv
// ---------------------------------------------------------------------------
// tb_adjacent_diff_1x8x32bit
//
// Scoreboard bench for adjacent_diff_1x8x32bit. The stimulus process pushes
// the expected result for each vector it issues. The monitor pops and
// compares whenever out_v is high.
//
// The monitor also runs a prefix-sum reconstruction on the output stream.
// Round-trip vectors are checked by comparing that reconstruction with the
// original input.
// ---------------------------------------------------------------------------
module tb_adjacent_diff_1x8x32bit;

  localparam int LAT = 4;

  logic         clk;
  logic         reset;
  logic [2:0]   vrd;
  logic         in_v;
  logic [255:0] in8;
  logic         out_v;
  logic [255:0] out8;
  logic [2:0]   out_vrd;

  adjacent_diff_1x8x32bit #(.LAT(LAT)) dut (
    .clk     (clk),
    .reset   (reset),
    .vrd     (vrd),
    .in_v    (in_v),
    .in8     (in8),
    .out_v   (out_v),
    .out8    (out8),
    .out_vrd (out_vrd)
  );

  typedef struct {
    logic [255:0] exp;
    logic [255:0] src;
    logic [2:0]   vrd;
    int           cyc;
    bit           roundTrip;
  } item_t;

  item_t        sb[$];
  int           checks = 0;
  int           errors = 0;
  int           cyc    = 0;

  // Monitor-side prefix-sum state
  logic [31:0]  pc = '0;
  logic [31:0]  cin;
  logic [255:0] recon;
  item_t        it;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle counter, used to measure each result's latency
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [255:0] pk(input logic [31:0] l0, input logic [31:0] l1,
                                      input logic [31:0] l2, input logic [31:0] l3,
                                      input logic [31:0] l4, input logic [31:0] l5,
                                      input logic [31:0] l6, input logic [31:0] l7);
    return {l7, l6, l5, l4, l3, l2, l1, l0};
  endfunction

  task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // Drive one vector for one cycle and optionally register its expected result
  task automatic applyStimulus(input logic [255:0] d, input logic [2:0] v,
                               input logic [255:0] e, input bit rt, input bit push);
    item_t x;
    in_v = 1'b1;
    in8  = d;
    vrd  = v;
    if (push) begin
      x.exp = e; x.src = d; x.vrd = v; x.cyc = cyc; x.roundTrip = rt;
      sb.push_back(x);
    end
    @(posedge clk);
    #1;
    in_v = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge clk);
    #1;
    if (sb.size() > 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain_timeout: got %0d results outstanding, required 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_out_v"},   256'(out_v),   256'(0));
    checkOutput({tag, "_out8"},    out8,          256'(0));
    checkOutput({tag, "_out_vrd"}, 256'(out_vrd), 256'(0));
  endtask

  task automatic doReset();
    @(posedge clk);
    #1 reset = 1'b0;
    #1 checkResetOutputs("rst");
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  // Monitor: pops one expected item per valid output
  always @(negedge clk) begin
    if (!reset) begin
      pc = '0;
    end else if (out_v) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL spurious_out_v: got out_v=1 out_vrd=%0d, required no output", out_vrd);
      end else begin
        it  = sb.pop_front();
        cin = (it.vrd == 3'd0) ? 32'd0 : pc;
        recon[31:0] = out8[31:0] + cin;
        for (int k = 1; k < 8; k++) recon[32*k +: 32] = out8[32*k +: 32] + recon[32*(k-1) +: 32];
        pc = recon[255:224];
        checkOutput("out_vrd", 256'(out_vrd), 256'(it.vrd));
        checkOutput("latency", 256'(cyc - it.cyc), 256'(LAT));
        if (it.roundTrip) checkOutput("roundtrip", recon, it.src);
        else              checkOutput("out8", out8, it.exp);
      end
    end
  end

  // Watchdog
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got simulation still running, required finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [255:0] rd;
    logic [2:0]   rv;

    reset = 1'b0;
    in_v  = 1'b0;
    in8   = '0;
    vrd   = 3'd0;
    #12 checkResetOutputs("init");
    @(posedge clk);
    #1 reset = 1'b1;

    // Single vector after reset, including a negative lane
    applyStimulus(pk(5, 7, 7, 10, 0, 1, 1, 100), 3'd3,
                  pk(5, 2, 0, 3, 32'hFFFFFFF6, 1, 0, 99), 1'b0, 1'b1);
    drain();

    // Back-to-back carry forwarding
    doReset();
    applyStimulus(pk(10, 10, 10, 10, 10, 10, 10, 10), 3'd1,
                  pk(10, 0, 0, 0, 0, 0, 0, 0), 1'b0, 1'b1);
    applyStimulus(pk(12, 13, 14, 15, 16, 17, 18, 19), 3'd1,
                  pk(2, 1, 1, 1, 1, 1, 1, 1), 1'b0, 1'b1);
    drain();

    // Carry held across bubbles, then restart with vrd=0
    doReset();
    applyStimulus(pk(50, 50, 50, 50, 50, 50, 50, 50), 3'd1,
                  pk(50, 0, 0, 0, 0, 0, 0, 0), 1'b0, 1'b1);
    idle(6);
    applyStimulus(pk(60, 60, 60, 60, 60, 60, 60, 60), 3'd2,
                  pk(10, 0, 0, 0, 0, 0, 0, 0), 1'b0, 1'b1);
    applyStimulus(pk(60, 60, 60, 60, 60, 60, 60, 60), 3'd0,
                  pk(60, 0, 0, 0, 0, 0, 0, 0), 1'b0, 1'b1);

    // Wrap-around subtraction
    applyStimulus({8{32'hFFFFFFFF}}, 3'd5,
                  pk(32'hFFFFFFC3, 0, 0, 0, 0, 0, 0, 0), 1'b0, 1'b1);
    applyStimulus(pk(0, 32'hFFFFFFFF, 0, 0, 0, 0, 0, 0), 3'd5,
                  pk(1, 32'hFFFFFFFF, 1, 0, 0, 0, 0, 0), 1'b0, 1'b1);
    drain();

    // Mid-stream reset discards in-flight vectors
    applyStimulus(pk(1, 2, 3, 4, 5, 6, 7, 8), 3'd1, '0, 1'b0, 1'b0);
    applyStimulus(pk(2, 3, 4, 5, 6, 7, 8, 9), 3'd2, '0, 1'b0, 1'b0);
    in_v  = 1'b1;
    in8   = pk(3, 4, 5, 6, 7, 8, 9, 10);
    vrd   = 3'd3;
    reset = 1'b0;
    #1 checkResetOutputs("midrst");
    in_v  = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    applyStimulus(pk(9, 9, 9, 9, 9, 9, 9, 9), 3'd4,
                  pk(9, 0, 0, 0, 0, 0, 0, 0), 1'b0, 1'b1);
    idle(10);
    drain();

    // Random round-trip through the prefix-sum reconstruction
    for (int n = 0; n < 10000; n++) begin
      for (int k = 0; k < 8; k++) rd[32*k +: 32] = $urandom;
      rv = ($urandom_range(0, 9) == 0) ? 3'd0 : 3'($urandom_range(1, 7));
      applyStimulus(rd, rv, '0, 1'b1, 1'b1);
      if ($urandom_range(0, 9) < 3) idle($urandom_range(1, 3));
    end
    drain();
    idle(5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
